// File: rtl/tt_io_capture.sv
`default_nettype none
// ============================================================================
// Module   : tt_io_capture
// Brief    : Timestamps every change on NCH 8-bit pin groups into a
//            first-word-fall-through FIFO read over a valid/ready port.
//            Optional trigger gating: define TT_IO_CAPTURE_TRIG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tt_io_capture #(
    parameter int NCH   = 3,
    parameter int DEPTH = 16,
    parameter int TSW   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [8*NCH-1:0]         pins_i,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [TSW+8*NCH:0]       evt_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
`ifdef TT_IO_CAPTURE_TRIG_EN
    ,
    input  logic [8*NCH-1:0]         trig_mask,
    input  logic [8*NCH-1:0]         trig_value,
    output logic                     triggered
`endif
);

    localparam int C_PW = 8 * NCH;
    localparam int C_EW = 1 + TSW + C_PW;
    localparam int C_AW = $clog2(DEPTH);
    localparam logic [C_AW:0] C_FULL = (C_AW + 1)'(DEPTH);

    logic [TSW-1:0]   r_ts;
    logic [C_PW-1:0]  r_prev;
    logic             r_lost;
    logic [C_EW-1:0]  r_mem [DEPTH];
    logic [C_AW-1:0]  r_head;
    logic [C_AW-1:0]  r_tail;
    logic [C_AW:0]    r_count;
    logic [7:0]       r_drop_cnt;

    logic             w_change;
    logic             w_push_req;
    logic             w_pop;
    logic             w_full;
    logic             w_push;
    logic             w_drop;
    logic [C_EW-1:0]  w_entry;

    assign w_change = (pins_i != r_prev);
    assign w_pop    = (r_count != '0) && evt_ready;
    assign w_full   = (r_count == C_FULL);
    assign w_entry  = {r_lost, r_ts, pins_i};

`ifdef TT_IO_CAPTURE_TRIG_EN
    logic r_triggered;
    logic w_match;

    assign w_match = ((pins_i & trig_mask) == (trig_value & trig_mask));
    // The matching edge itself is logged even when the pins did not change.
    assign w_push_req = en && (r_triggered ? w_change : w_match);

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_triggered <= 1'b0;
        end else if (w_match) begin
            r_triggered <= 1'b1;
        end
    end

    assign triggered = r_triggered;
`else
    assign w_push_req = en && w_change;
`endif

    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push = w_push_req && (!w_full || w_pop);
    assign w_drop = w_push_req && !w_push;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts       <= '0;
            r_prev     <= '0;
            r_lost     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (en) begin
                r_ts   <= r_ts + 1'b1;
                r_prev <= pins_i;
            end

            if (w_push) begin
                r_tail <= r_tail + 1'b1;
                r_lost <= 1'b0;
            end else if (w_drop) begin
                r_lost <= 1'b1;
            end

            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end

            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_tail] <= w_entry;
        end
    end

    assign evt_valid = (r_count != '0);
    assign evt_data  = evt_valid ? r_mem[r_head] : '0;
    assign count     = r_count;
    assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire
